// File: rtl/keycode_pkg.sv
// ----------------------------------------------------------------------------
// keycode_pkg
// Shared types and constants for the keycode event controller slice.
//   evt_kind_t : kind field of a queued key event (PRESS / RELEASE / REPEAT)
//   kstate_t   : key tracking FSM states
//   KEY_NONE   : keycode value meaning "no key held"
//   EVT_W      : width of one FIFO entry {kind, code}
//   maxOf()    : elaboration-time helper used to size the repeat counter
// ----------------------------------------------------------------------------
package keycode_pkg;

    typedef enum logic [1:0] {
        KEV_PRESS   = 2'd0,
        KEV_RELEASE = 2'd1,
        KEV_REPEAT  = 2'd2
    } evt_kind_t;

    typedef enum logic [1:0] {
        KS_IDLE = 2'd0,
        KS_HELD = 2'd1,
        KS_SWAP = 2'd2
    } kstate_t;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam int         EVT_W    = 10;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keycode_evt_fifo.sv
// ----------------------------------------------------------------------------
// keycode_evt_fifo
// Synchronous FIFO holding {kind, code} key events between the key tracking
// FSM and the game logic consumer.
//
// Parameters:
//   FIFO_DEPTH : number of entries (power of two, >= 2)
// Ports:
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset, empties the FIFO
//   i_push   : write request for i_data
//   i_data   : event {kind[1:0], code[7:0]}
//   i_pop    : read request, ignored while empty
//   o_data   : head entry (all zero after reset)
//   o_full   : all entries occupied
//   o_empty  : no entries occupied
// ----------------------------------------------------------------------------
module keycode_evt_fifo
    import keycode_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [EVT_W-1:0] i_data,
    input  logic             i_pop,
    output logic [EVT_W-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    // A pop frees the head slot at the same edge, so a push into a full FIFO
    // still lands when it is paired with a pop.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    assign o_data = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr[AW-1:0]] <= i_data;
                r_wrPtr                <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keycode_evt_ctrl.sv
// ----------------------------------------------------------------------------
// keycode_evt_ctrl
// Turns the keycode level from the keycode PIO (0x00 = no key) into a queued
// stream of PRESS / RELEASE / REPEAT events for the game logic, delivered over
// a valid/ready handshake from a small FIFO.
//
// Build option:
//   KEYCODE_AUTOREPEAT_EN : when defined, a held key generates REPEAT events
//                           paced by frame_tick. When undefined, frame_tick
//                           is ignored and REPEAT is never produced.
//
// Parameters:
//   FIFO_DEPTH    : event FIFO entries (power of two, >= 2)
//   REPEAT_DELAY  : frame ticks from PRESS to first REPEAT (>= 1)
//   REPEAT_PERIOD : frame ticks between successive REPEATs (>= 1)
// Ports:
//   Clk        : clock for all state
//   Reset      : asynchronous active-high reset
//   keycode    : keycode level, synchronous to Clk
//   frame_tick : one-cycle pulse per video frame
//   evt_valid  : head event available
//   evt_ready  : consumer takes the head event when high with evt_valid
//   evt_code   : keycode of head event
//   evt_kind   : 0 = PRESS, 1 = RELEASE, 2 = REPEAT
//   ovf        : sticky, an event was dropped on a full FIFO
//   ovf_clr    : clears ovf (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module keycode_evt_ctrl
    import keycode_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       frame_tick,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic [1:0] evt_kind,
    output logic       ovf,
    input  logic       ovf_clr
);

    kstate_t          r_state;
    kstate_t          w_stateNext;
    logic [7:0]       r_curCode;
    logic [7:0]       w_curNext;
    logic             w_push;
    evt_kind_t        w_pushKind;
    logic [7:0]       w_pushCode;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic [EVT_W-1:0] w_head;
    logic             r_ovf;

`ifdef KEYCODE_AUTOREPEAT_EN
    localparam int CNT_MAX = maxOf(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] r_rptCnt;
    logic [CNT_W-1:0] w_cntInc;
    logic [CNT_W-1:0] w_target;
    logic             r_rptPhase;
    logic             w_rptTick;
    logic             w_rptHit;

    // A tick only counts while the same key stays held; a keycode change in
    // the same cycle takes priority and the tick is lost.
    assign w_rptTick = (r_state == KS_HELD) && (keycode == r_curCode) && frame_tick;
    assign w_cntInc  = r_rptCnt + 1'b1;

    // Phase 0 waits for the initial delay, phase 1 paces the periodic repeats.
    assign w_target  = r_rptPhase ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY);
    assign w_rptHit  = (w_cntInc == w_target);

    // Counter is held at zero outside HELD, so every PRESS enters HELD with a
    // fresh count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rptCnt   <= '0;
            r_rptPhase <= 1'b0;
        end else if (r_state != KS_HELD) begin
            r_rptCnt   <= '0;
            r_rptPhase <= 1'b0;
        end else if (w_rptTick) begin
            if (w_rptHit) begin
                r_rptCnt   <= '0;
                r_rptPhase <= 1'b1;
            end else if (r_rptCnt != CNT_W'(CNT_MAX)) begin
                r_rptCnt <= w_cntInc;
            end
        end
    end
`else
    logic w_unusedCfg;
    assign w_unusedCfg = ^{frame_tick, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= KS_IDLE;
            r_curCode <= KEY_NONE;
        end else begin
            r_state   <= w_stateNext;
            r_curCode <= w_curNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_curNext   = r_curCode;
        w_push      = 1'b0;
        w_pushKind  = KEV_PRESS;
        w_pushCode  = KEY_NONE;

        case (r_state)
            KS_IDLE: begin
                if (keycode != KEY_NONE) begin
                    w_push      = 1'b1;
                    w_pushKind  = KEV_PRESS;
                    w_pushCode  = keycode;
                    w_curNext   = keycode;
                    w_stateNext = KS_HELD;
                end
            end
            KS_HELD: begin
                if (keycode == KEY_NONE) begin
                    w_push      = 1'b1;
                    w_pushKind  = KEV_RELEASE;
                    w_pushCode  = r_curCode;
                    w_curNext   = KEY_NONE;
                    w_stateNext = KS_IDLE;
                end else if (keycode != r_curCode) begin
                    // Release the old key now, press the new one next cycle,
                    // keeping to one push per cycle.
                    w_push      = 1'b1;
                    w_pushKind  = KEV_RELEASE;
                    w_pushCode  = r_curCode;
                    w_stateNext = KS_SWAP;
                end
`ifdef KEYCODE_AUTOREPEAT_EN
                else if (frame_tick && w_rptHit) begin
                    w_push     = 1'b1;
                    w_pushKind = KEV_REPEAT;
                    w_pushCode = r_curCode;
                end
`endif
            end
            KS_SWAP: begin
                // Keycode is resampled here; if the key went away during the
                // swap there is nothing left to press.
                if (keycode == KEY_NONE) begin
                    w_curNext   = KEY_NONE;
                    w_stateNext = KS_IDLE;
                end else begin
                    w_push      = 1'b1;
                    w_pushKind  = KEV_PRESS;
                    w_pushCode  = keycode;
                    w_curNext   = keycode;
                    w_stateNext = KS_HELD;
                end
            end
            default: begin
                w_curNext   = KEY_NONE;
                w_stateNext = KS_IDLE;
            end
        endcase
    end

    assign w_pop  = evt_ready && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    keycode_evt_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_data  ({w_pushKind, w_pushCode}),
        .i_pop   (evt_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Drop sets the sticky flag and wins over a same-cycle clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign evt_valid = !w_empty;
    assign evt_kind  = w_head[9:8];
    assign evt_code  = w_head[7:0];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_keycode_evt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_keycode_evt_ctrl
// Self-checking bench for keycode_evt_ctrl (FIFO_DEPTH = 4, REPEAT_DELAY = 3,
// REPEAT_PERIOD = 2). Expected events are queued as stimulus is driven and
// compared as the DUT hands them out. REPEAT expectations follow the
// KEYCODE_AUTOREPEAT_EN build option.
// ----------------------------------------------------------------------------
module tb_keycode_evt_ctrl;

    localparam logic [1:0] K_PRESS = 2'd0;
    localparam logic [1:0] K_REL   = 2'd1;
    localparam logic [1:0] K_REP   = 2'd2;

    logic       Clk;
    logic       Reset;
    logic [7:0] keycode;
    logic       frame_tick;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic [1:0] evt_kind;
    logic       ovf;
    logic       ovf_clr;

    logic [9:0] expQ [$];
    int         checks;
    int         errors;

    keycode_evt_ctrl #(
        .FIFO_DEPTH    (4),
        .REPEAT_DELAY  (3),
        .REPEAT_PERIOD (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .keycode    (keycode),
        .frame_tick (frame_tick),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_kind   (evt_kind),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic test_reset();
        Reset      = 1'b1;
        keycode    = 8'h00;
        frame_tick = 1'b0;
        evt_ready  = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b, required 0", evt_valid);
        end
        checks++;
        if (evt_code !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_code: got %02h, required 00", evt_code);
        end
        checks++;
        if (evt_kind !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_kind: got %0d, required 0", evt_kind);
        end
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ovf: got %b, required 0", ovf);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_valid: got %b, required 0", evt_valid);
        end
    endtask

    task automatic test_press_release();
        logic [9:0] exp;
        logic [7:0] seq [8] = '{8'h1A, 8'h1A, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            keycode = seq[i];
            if (i == 0) expQ.push_back({K_PRESS, 8'h1A});
            if (i == 3) expQ.push_back({K_REL, 8'h1A});
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL press_release_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL press_release_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL press_release_missing: %0d events outstanding, required 0", expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_swap();
        logic [9:0] exp;
        int relCyc;
        int prsCyc;
        logic [7:0] seq [8] = '{8'h04, 8'h04, 8'h07, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00};
        relCyc = -1;
        prsCyc = -1;
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            keycode = seq[i];
            if (i == 0) expQ.push_back({K_PRESS, 8'h04});
            if (i == 2) begin
                expQ.push_back({K_REL, 8'h04});
                expQ.push_back({K_PRESS, 8'h07});
            end
            if (i == 5) expQ.push_back({K_REL, 8'h07});
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL swap_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL swap_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                    if (exp == {K_REL, 8'h04}) relCyc = i;
                    if (exp == {K_PRESS, 8'h07}) prsCyc = i;
                end
            end
        end
        checks++;
        if (relCyc < 0 || prsCyc != relCyc + 1) begin
            errors++;
            $display("[TB] FAIL swap_consecutive: release at cycle %0d press at cycle %0d, required adjacent cycles", relCyc, prsCyc);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL swap_missing: %0d events outstanding, required 0", expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_autorepeat();
        logic [9:0] exp;
        int tickNum;
        tickNum = 0;
        evt_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge Clk);
            keycode    = (i < 20) ? 8'h2C : 8'h00;
            frame_tick = (i >= 2 && i <= 18 && (i % 2) == 0);
            if (i == 0) expQ.push_back({K_PRESS, 8'h2C});
            if (frame_tick) begin
                tickNum++;
`ifdef KEYCODE_AUTOREPEAT_EN
                if (tickNum == 3 || tickNum == 5 || tickNum == 7 || tickNum == 9)
                    expQ.push_back({K_REP, 8'h2C});
`endif
            end
            if (i == 20) expQ.push_back({K_REL, 8'h2C});
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL repeat_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL repeat_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                end
            end
        end
        frame_tick = 1'b0;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL repeat_missing: %0d events outstanding, required 0", expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_overflow();
        logic [9:0] exp;
        logic [7:0] seq [5] = '{8'h11, 8'h00, 8'h12, 8'h00, 8'h13};
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (i == 4) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_before_drop: got %b, required 0", ovf);
                end
            end
            keycode = seq[i];
            case (i)
                0: expQ.push_back({K_PRESS, 8'h11});
                1: expQ.push_back({K_REL, 8'h11});
                2: expQ.push_back({K_PRESS, 8'h12});
                3: expQ.push_back({K_REL, 8'h12});
                default: ;
            endcase
        end
        @(negedge Clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: got %b, required 1", ovf);
        end
        checks++;
        if ({evt_valid, evt_kind, evt_code} !== {1'b1, K_PRESS, 8'h11}) begin
            errors++;
            $display("[TB] FAIL stall_head: got valid=%b kind=%0d code=%02h, required valid=1 kind=0 code=11", evt_valid, evt_kind, evt_code);
        end
        @(negedge Clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got %b, required 1", ovf);
        end
        ovf_clr = 1'b1;
        @(negedge Clk);
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clr: got %b, required 0", ovf);
        end
        evt_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge Clk);
            if (i == 5) begin
                keycode = 8'h00;
                expQ.push_back({K_REL, 8'h13});
            end
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL overflow_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL overflow_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                end
            end
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL overflow_missing: %0d events outstanding, required 0", expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_full_push_pop();
        logic [9:0] exp;
        logic [7:0] seq [4] = '{8'h21, 8'h00, 8'h22, 8'h00};
        evt_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clk);
            if (i < 4) begin
                keycode = seq[i];
            end else begin
                keycode   = (i < 9) ? 8'h23 : 8'h00;
                evt_ready = 1'b1;
            end
            case (i)
                0: expQ.push_back({K_PRESS, 8'h21});
                1: expQ.push_back({K_REL, 8'h21});
                2: expQ.push_back({K_PRESS, 8'h22});
                3: expQ.push_back({K_REL, 8'h22});
                4: expQ.push_back({K_PRESS, 8'h23});
                9: expQ.push_back({K_REL, 8'h23});
                default: ;
            endcase
            if (i == 5) begin
                checks++;
                if (ovf !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL full_push_pop_ovf: got %b, required 0", ovf);
                end
            end
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL full_push_pop_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL full_push_pop_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                end
            end
        end
        checks++;
        if (expQ.size() != 0 || ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_push_pop_end: %0d outstanding ovf=%b, required 0 outstanding ovf=0", expQ.size(), ovf);
        end
        expQ.delete();
    endtask

    task automatic test_reset_midop();
        logic [9:0] exp;
        logic [7:0] seq [3] = '{8'h16, 8'h00, 8'h16};
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            keycode = seq[i];
            if (i == 0) expQ.push_back({K_PRESS, 8'h16});
            if (i == 1) expQ.push_back({K_REL, 8'h16});
            if (i == 2) begin
                expQ.push_back({K_PRESS, 8'h16});
                evt_ready = 1'b1;
            end
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL midreset_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL midreset_pre_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                end
            end
        end
        @(negedge Clk);
        evt_ready = 1'b0;
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_queued: valid=%b, required 1 with two events queued", evt_valid);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_valid: got %b, required 0", evt_valid);
        end
        expQ.delete();
        repeat (2) @(negedge Clk);
        Reset     = 1'b0;
        evt_ready = 1'b1;
        expQ.push_back({K_PRESS, 8'h16});
        @(negedge Clk);
        checks++;
        if (evt_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_press_latency: valid=%b, required 1", evt_valid);
        end
        for (int i = 0; i < 6; i++) begin
            keycode = (i < 3) ? 8'h16 : 8'h00;
            if (i == 3) expQ.push_back({K_REL, 8'h16});
            if (evt_valid && evt_ready) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL midreset_extra: got kind=%0d code=%02h, required no event", evt_kind, evt_code);
                end else begin
                    exp = expQ.pop_front();
                    if ({evt_kind, evt_code} !== exp) begin
                        errors++;
                        $display("[TB] FAIL midreset_evt: got kind=%0d code=%02h, required kind=%0d code=%02h", evt_kind, evt_code, exp[9:8], exp[7:0]);
                    end
                end
            end
            @(negedge Clk);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_missing: %0d events outstanding, required 0", expQ.size());
        end
        expQ.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_press_release();
        test_swap();
        test_autorepeat();
        test_overflow();
        test_full_push_pop();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
